// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the coherent-bus request arbiter.
// Holds the FSM state encoding and a one-hot to binary helper.
package bus_arb_pkg;

  localparam int unsigned DEF_NUM_REQ        = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 50;
  localparam int unsigned MAX_REQ            = 16;
  localparam int unsigned MAX_ID_W           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACTIVE = 2'd2
  } arb_state_t;

  // OR of the indices of all set bits; exact for one-hot or zero input.
  function automatic logic [MAX_ID_W-1:0] onehot_to_bin(input logic [MAX_REQ-1:0] oh);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | MAX_ID_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_req_arbiter_rr_pick.sv
// Round-robin winner selection: first request at or after ptr, wrapping.
// Lower half of the doubled vector holds requests masked below ptr, upper half the full set.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [ID_W-1:0]    winner_id
);

  localparam int unsigned DBL_W = 2 * NUM_REQ;

  logic [NUM_REQ-1:0] mask;
  logic [DBL_W-1:0]   dbl;
  logic               found;

  always_comb begin
    mask      = '0;
    winner    = '0;
    winner_id = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (ID_W'(i) >= ptr);
    end
    dbl = {req, req & mask};
    for (int i = 0; i < DBL_W; i++) begin
      if (!found && dbl[i]) begin
        found     = 1'b1;
        winner_id = ID_W'(i % NUM_REQ);
        winner    = NUM_REQ'(1) << (i % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/bus_req_arbiter.sv
// Round-robin arbiter in front of the coherent bus controller: grants one cache at a time,
// sequences start/done with the controller and aborts stalled transactions via a watchdog.
module bus_req_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned ID_W           = $clog2(NUM_REQ)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ctrl_ready,
  input  logic               ctrl_done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               ctrl_start,
  output logic               timeout,
  output logic               busy
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    ptr_after;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .winner    (pick_grant),
    .winner_id (pick_id)
  );

  assign ptr_after = (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      wd_q      <= '0;
      grant_q   <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wd_q      <= wd_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state; the pointer only moves when a transaction finishes or is aborted.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wd_d       = wd_q;
    grant_d    = grant_q;
    id_d       = id_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    ctrl_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (|req) begin
          state_d = GRANT;
          grant_d = pick_grant;
          id_d    = pick_id;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (ctrl_ready) begin
          ctrl_start = 1'b1;
          state_d    = ACTIVE;
          wd_d       = '0;
        end else if (!(|(req & grant_q))) begin
          state_d = IDLE;
          grant_d = '0;
          id_d    = '0;
          valid_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (ctrl_done || (wd_q == WD_LAST)) begin
          state_d   = IDLE;
          ptr_d     = ptr_after;
          wd_d      = '0;
          grant_d   = '0;
          id_d      = '0;
          valid_d   = 1'b0;
          timeout_d = !ctrl_done;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
  assign timeout     = timeout_q;
  assign busy        = valid_q;

  a_grant_onehot: assert property (@(posedge CLK) disable iff (!nRST)
    $onehot0(grant));
  a_grant_valid: assert property (@(posedge CLK) disable iff (!nRST)
    ((grant != '0) == grant_valid));
  a_grant_id: assert property (@(posedge CLK) disable iff (!nRST)
    grant_valid |-> (grant_id == ID_W'(onehot_to_bin(MAX_REQ'(grant)))));

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Self-checking bench for bus_req_arbiter: expected grant ids are queued when requests
// are driven and popped when the arbiter presents a grant.
module tb_bus_req_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned TMO     = 50;
  localparam int unsigned ID_W    = 1;

  logic               CLK = 1'b0;
  logic               nRST;
  logic [NUM_REQ-1:0] req;
  logic               ctrl_ready;
  logic               ctrl_done;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic               ctrl_start;
  logic               timeout;
  logic               busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int exp_q[$];

  bus_req_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .req         (req),
    .ctrl_ready  (ctrl_ready),
    .ctrl_done   (ctrl_done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .ctrl_start  (ctrl_start),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    nRST = 1'b0; req = '0; ctrl_ready = 1'b0; ctrl_done = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    tick();
  endtask

  function automatic int pop_exp();
    return (exp_q.size() > 0) ? exp_q.pop_front() : -1;
  endfunction

  task automatic test_reset();
    int e;
    logic [NUM_REQ-1:0] oh;
    nRST = 1'b0; req = 2'b11; ctrl_ready = 1'b0; ctrl_done = 1'b0;
    tick(); tick(); tick();
    chk_cnt++;
    if ({grant, grant_valid, grant_id, ctrl_start, timeout, busy} !== 7'd0)
      $display("FAIL reset_outputs: got %b want 0000000",
               {grant, grant_valid, grant_id, ctrl_start, timeout, busy});
    else pass_cnt++;
    exp_q.push_back(0);
    nRST = 1'b1;
    tick();
    e  = pop_exp();
    oh = NUM_REQ'(1) << e;
    chk_cnt++;
    if ({grant_valid, busy} !== 2'b11) $display("FAIL reset_release_valid: got %b want 11", {grant_valid, busy});
    else pass_cnt++;
    chk_cnt++;
    if (grant !== oh) $display("FAIL reset_release_grant: got %b want %b", grant, oh);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    int e, cyc, idle;
    logic [NUM_REQ-1:0] oh;
    do_reset();
    req = 2'b11; ctrl_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    for (int t = 0; t < 4; t++) begin
      cyc = 0;
      while (!grant_valid && cyc < 20) begin tick(); cyc++; end
      chk_cnt++;
      if (grant_valid !== 1'b1) $display("FAIL fair_wait%0d: got %b want 1", t, grant_valid);
      else pass_cnt++;
      e  = pop_exp();
      oh = NUM_REQ'(1) << e;
      chk_cnt++;
      if (grant_id !== ID_W'(e) || grant !== oh)
        $display("FAIL fair_order%0d: got id %0d grant %b want id %0d grant %b", t, grant_id, grant, e, oh);
      else pass_cnt++;
      chk_cnt++;
      if (ctrl_start !== 1'b1) $display("FAIL fair_start%0d: got %b want 1", t, ctrl_start);
      else pass_cnt++;
      tick(); tick(); tick(); tick();
      ctrl_done = 1'b1;
      tick();
      ctrl_done = 1'b0;
      idle = 0;
      while (!grant_valid && idle < 20) begin idle++; tick(); end
      chk_cnt++;
      if (idle != 1) $display("FAIL fair_gap%0d: got %0d idle cycles want 1", t, idle);
      else pass_cnt++;
    end
  endtask

  task automatic test_cancel();
    int e;
    do_reset();
    req = 2'b01; ctrl_ready = 1'b1;
    exp_q.push_back(0);
    tick();
    e = pop_exp();
    chk_cnt++;
    if (grant_id !== ID_W'(e) || grant_valid !== 1'b1)
      $display("FAIL cancel_first: got id %0d valid %b want id %0d valid 1", grant_id, grant_valid, e);
    else pass_cnt++;
    tick();
    ctrl_ready = 1'b0; ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0; req = 2'b11;
    exp_q.push_back(1);
    tick();
    e = pop_exp();
    chk_cnt++;
    if (grant_id !== ID_W'(e) || grant !== 2'b10)
      $display("FAIL cancel_grant1: got id %0d grant %b want id %0d grant 10", grant_id, grant, e);
    else pass_cnt++;
    req = 2'b01;
    #1;
    chk_cnt++;
    if (ctrl_start !== 1'b0) $display("FAIL cancel_nostart: got %b want 0", ctrl_start);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({grant_valid, busy, grant} !== 4'b0000)
      $display("FAIL cancel_idle: got %b want 0000", {grant_valid, busy, grant});
    else pass_cnt++;
    req = 2'b11;
    exp_q.push_back(1);
    tick();
    e = pop_exp();
    chk_cnt++;
    if (grant_id !== ID_W'(e) || grant_valid !== 1'b1)
      $display("FAIL cancel_ptr_kept: got id %0d valid %b want id %0d valid 1", grant_id, grant_valid, e);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int e, pulses, first;
    logic busy_at, valid_after;
    logic [ID_W-1:0] id_after;
    do_reset();
    req = 2'b01; ctrl_ready = 1'b1;
    exp_q.push_back(0);
    tick();
    e = pop_exp();
    chk_cnt++;
    if (grant_id !== ID_W'(e) || ctrl_start !== 1'b1)
      $display("FAIL tmo_start: got id %0d start %b want id %0d start 1", grant_id, ctrl_start, e);
    else pass_cnt++;
    tick();
    ctrl_ready = 1'b0; req = 2'b11;
    exp_q.push_back(1);
    pulses = 0; first = -1; busy_at = 1'b1; valid_after = 1'b0; id_after = '0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (first > 0 && k == first + 1) begin id_after = grant_id; valid_after = grant_valid; end
      if (timeout) begin
        pulses++;
        if (first < 0) begin first = k; busy_at = busy; end
      end
    end
    chk_cnt++;
    if (first != int'(TMO)) $display("FAIL tmo_latency: got %0d want %0d", first, TMO);
    else pass_cnt++;
    chk_cnt++;
    if (pulses != 1) $display("FAIL tmo_pulses: got %0d want 1", pulses);
    else pass_cnt++;
    chk_cnt++;
    if (busy_at !== 1'b0) $display("FAIL tmo_idle: got busy %b want 0", busy_at);
    else pass_cnt++;
    e = pop_exp();
    chk_cnt++;
    if (id_after !== ID_W'(e) || valid_after !== 1'b1)
      $display("FAIL tmo_next_grant: got id %0d valid %b want id %0d valid 1", id_after, valid_after, e);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    int e, pulses;
    do_reset();
    req = 2'b01; ctrl_ready = 1'b1;
    exp_q.push_back(0);
    tick();
    e = pop_exp();
    chk_cnt++;
    if (grant_id !== ID_W'(e) || ctrl_start !== 1'b1)
      $display("FAIL coll_start: got id %0d start %b want id %0d start 1", grant_id, ctrl_start, e);
    else pass_cnt++;
    tick();
    ctrl_ready = 1'b0; req = 2'b00;
    repeat (TMO - 1) tick();
    chk_cnt++;
    if ({timeout, busy} !== 2'b01) $display("FAIL coll_last_cycle: got %b want 01", {timeout, busy});
    else pass_cnt++;
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0;
    chk_cnt++;
    if ({timeout, busy, grant_valid} !== 3'b000)
      $display("FAIL coll_done_wins: got %b want 000", {timeout, busy, grant_valid});
    else pass_cnt++;
    pulses = 0;
    repeat (5) begin tick(); if (timeout) pulses++; end
    chk_cnt++;
    if (pulses != 0) $display("FAIL coll_no_late_pulse: got %0d want 0", pulses);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int e;
    do_reset();
    req = 2'b01; ctrl_ready = 1'b1;
    exp_q.push_back(0);
    tick();
    e = pop_exp();
    chk_cnt++;
    if (grant_id !== ID_W'(e) || grant_valid !== 1'b1)
      $display("FAIL arst_grant: got id %0d valid %b want id %0d valid 1", grant_id, grant_valid, e);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL arst_active: got busy %b want 1", busy);
    else pass_cnt++;
    #2;
    nRST = 1'b0;
    #1;
    chk_cnt++;
    if ({grant, grant_valid, busy} !== 4'b0000)
      $display("FAIL arst_drop: got %b want 0000", {grant, grant_valid, busy});
    else pass_cnt++;
    req = 2'b00; ctrl_done = 1'b1; ctrl_ready = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    chk_cnt++;
    if ({busy, timeout, grant_valid} !== 3'b000)
      $display("FAIL arst_stray_done: got %b want 000", {busy, timeout, grant_valid});
    else pass_cnt++;
    ctrl_done = 1'b0; req = 2'b11;
    exp_q.push_back(0);
    tick();
    e = pop_exp();
    chk_cnt++;
    if (grant_id !== ID_W'(e) || grant !== 2'b01)
      $display("FAIL arst_ptr_reset: got id %0d grant %b want id %0d grant 01", grant_id, grant, e);
    else pass_cnt++;
  endtask

  initial begin
    nRST = 1'b0; req = '0; ctrl_ready = 1'b0; ctrl_done = 1'b0;
    test_reset();
    test_fairness();
    test_cancel();
    test_timeout();
    test_collision();
    test_async_reset();
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
